// File: rtl/shader_pkg.sv
// Shared types for the shader core's vector datapath.
// Covers 128-bit vectors, ALU opcodes, condition flags and the default register count.
package shader_pkg;

    localparam int NREGS_DEF = 8;

    typedef logic [127:0] vec_t;
    typedef logic [2:0]   op_t;
    typedef logic [2:0]   nzp_t;

endpackage

// File: rtl/vec_regfile.sv
// Vector register file with two asynchronous read ports, a retire write port and a host load port.
// When the load port and the retire port hit the same register on one edge, the load wins.
module vec_regfile
    import shader_pkg::*;
#(
    parameter int  NREGS = NREGS_DEF,
    localparam int RAW   = $clog2(NREGS)
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic [RAW-1:0] i_rd0_addr,
    output vec_t           o_rd0_data,
    input  logic [RAW-1:0] i_rd1_addr,
    output vec_t           o_rd1_data,
    input  logic           i_wr_en,
    input  logic [RAW-1:0] i_wr_addr,
    input  vec_t           i_wr_data,
    input  logic           i_ld_en,
    input  logic [RAW-1:0] i_ld_addr,
    input  vec_t           i_ld_data
);

    vec_t r_regs [NREGS];

    assign o_rd0_data = r_regs[i_rd0_addr];
    assign o_rd1_data = r_regs[i_rd1_addr];

    // The load assignment comes last, so it overrides a retire to the same register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (i_wr_en) begin
                r_regs[i_wr_addr] <= i_wr_data;
            end
            if (i_ld_en) begin
                r_regs[i_ld_addr] <= i_ld_data;
            end
        end
    end

endmodule

// File: rtl/vec_issue_unit.sv
// Operand-issue and writeback sequencer for the 4-lane vector ALU.
// Instructions are accepted and read from the register file, then issued from a registered stage (S1) that retires the ALU result.
module vec_issue_unit
    import shader_pkg::*;
#(
    parameter int  NREGS = NREGS_DEF,
    localparam int RAW   = $clog2(NREGS)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           instr_valid,
    output logic           instr_ready,
    input  op_t            instr_op,
    input  logic [RAW-1:0] instr_dst,
    input  logic [RAW-1:0] instr_src,
    input  logic [7:0]     instr_swizzle,
    input  logic [3:0]     instr_wmask,
    input  logic           ld_valid,
    input  logic [RAW-1:0] ld_addr,
    input  vec_t           ld_data,
    output vec_t           alu_dest,
    output vec_t           alu_arg,
    output op_t            alu_op,
    output logic [7:0]     alu_swizzle,
    output logic [3:0]     alu_write_mask,
    input  vec_t           alu_dest_out,
    input  nzp_t           alu_nzp,
    output logic           retire_valid,
    output logic [RAW-1:0] retire_dst,
    output nzp_t           flags_nzp,
    output logic           busy
);

    logic           r_s1_valid;
    logic [RAW-1:0] r_s1_dst;
    vec_t           r_dest;
    vec_t           r_arg;
    op_t            r_op;
    logic [7:0]     r_swizzle;
    logic [3:0]     r_wmask;
    logic           r_retire_valid;
    logic [RAW-1:0] r_retire_dst;
    nzp_t           r_flags;

    logic w_accept;
    logic w_fwd_dest;
    logic w_fwd_arg;
    vec_t w_rf_dest;
    vec_t w_rf_arg;
    vec_t w_dest;
    vec_t w_arg;

    // Handshake: an instruction transfers on a clock edge where instr_valid && instr_ready.
    // A host load always takes precedence, and there is no other source of backpressure.
    assign instr_ready = !ld_valid;
    assign w_accept    = instr_valid && instr_ready;

    vec_regfile #(.NREGS(NREGS)) u_regfile (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rd0_addr (instr_dst),
        .o_rd0_data (w_rf_dest),
        .i_rd1_addr (instr_src),
        .o_rd1_data (w_rf_arg),
        .i_wr_en    (r_s1_valid),
        .i_wr_addr  (r_s1_dst),
        .i_wr_data  (alu_dest_out),
        .i_ld_en    (ld_valid),
        .i_ld_addr  (ld_addr),
        .i_ld_data  (ld_data)
    );

    // The S1 result is written back on this same edge, so the register file still holds the stale value.
    assign w_fwd_dest = r_s1_valid && (r_s1_dst == instr_dst);
    assign w_fwd_arg  = r_s1_valid && (r_s1_dst == instr_src);
    assign w_dest     = w_fwd_dest ? alu_dest_out : w_rf_dest;
    assign w_arg      = w_fwd_arg  ? alu_dest_out : w_rf_arg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid     <= 1'b0;
            r_s1_dst       <= '0;
            r_dest         <= '0;
            r_arg          <= '0;
            r_op           <= '0;
            r_swizzle      <= '0;
            r_wmask        <= '0;
            r_retire_valid <= 1'b0;
            r_retire_dst   <= '0;
            r_flags        <= '0;
        end else begin
            r_s1_valid     <= w_accept;
            r_retire_valid <= r_s1_valid;
            if (w_accept) begin
                r_s1_dst  <= instr_dst;
                r_dest    <= w_dest;
                r_arg     <= w_arg;
                r_op      <= instr_op;
                r_swizzle <= instr_swizzle;
                r_wmask   <= instr_wmask;
            end
            if (r_s1_valid) begin
                r_retire_dst <= r_s1_dst;
                r_flags      <= alu_nzp;
            end
        end
    end

    assign alu_dest       = r_dest;
    assign alu_arg        = r_arg;
    assign alu_op         = r_op;
    assign alu_swizzle    = r_swizzle;
    assign alu_write_mask = r_wmask;
    assign retire_valid   = r_retire_valid;
    assign retire_dst     = r_retire_dst;
    assign flags_nzp      = r_flags;
    assign busy           = r_s1_valid;

endmodule

// File: tb/tb_vec_issue_unit.sv
// Directed and random checks of vec_issue_unit against an in-order architectural model.
// The bench supplies its own ALU, which computes dest_out = dest ^ arg.
module tb_vec_issue_unit;
    import shader_pkg::*;

    localparam int NREGS = 8;
    localparam int RAW   = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           instr_valid;
    logic           instr_ready;
    op_t            instr_op;
    logic [RAW-1:0] instr_dst;
    logic [RAW-1:0] instr_src;
    logic [7:0]     instr_swizzle;
    logic [3:0]     instr_wmask;
    logic           ld_valid;
    logic [RAW-1:0] ld_addr;
    vec_t           ld_data;
    vec_t           alu_dest;
    vec_t           alu_arg;
    op_t            alu_op;
    logic [7:0]     alu_swizzle;
    logic [3:0]     alu_write_mask;
    vec_t           alu_dest_out;
    nzp_t           alu_nzp;
    logic           retire_valid;
    logic [RAW-1:0] retire_dst;
    nzp_t           flags_nzp;
    logic           busy;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    vec_issue_unit #(.NREGS(NREGS)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_op       (instr_op),
        .instr_dst      (instr_dst),
        .instr_src      (instr_src),
        .instr_swizzle  (instr_swizzle),
        .instr_wmask    (instr_wmask),
        .ld_valid       (ld_valid),
        .ld_addr        (ld_addr),
        .ld_data        (ld_data),
        .alu_dest       (alu_dest),
        .alu_arg        (alu_arg),
        .alu_op         (alu_op),
        .alu_swizzle    (alu_swizzle),
        .alu_write_mask (alu_write_mask),
        .alu_dest_out   (alu_dest_out),
        .alu_nzp        (alu_nzp),
        .retire_valid   (retire_valid),
        .retire_dst     (retire_dst),
        .flags_nzp      (flags_nzp),
        .busy           (busy)
    );

    assign alu_dest_out = alu_dest ^ alu_arg;
    assign alu_nzp      = {alu_dest_out == '0, 1'b0, alu_dest_out != '0};

    // ---------------- reference model / scoreboard ----------------
    vec_t           m_regs [NREGS];
    logic [RAW-1:0] exp_q [$];
    nzp_t           nzp_q [$];
    vec_t           exp_dest;
    vec_t           exp_arg;
    op_t            exp_op;
    logic [7:0]     exp_swz;
    logic [3:0]     exp_wm;
    nzp_t           exp_flags;
    logic [RAW-1:0] exp_rdst;
    logic           exp_rv;
    int             tests_run = 0;
    int             tests_failed = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
        exp_q.delete();
        nzp_q.delete();
        exp_dest  = '0;
        exp_arg   = '0;
        exp_op    = '0;
        exp_swz   = '0;
        exp_wm    = '0;
        exp_flags = '0;
        exp_rdst  = '0;
        exp_rv    = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    // One clock cycle: drive, check the ready, advance the model at the edge, check the outputs.
    task automatic step(input logic iv, input logic [RAW-1:0] dst, input logic [RAW-1:0] src,
                        input logic lv, input logic [RAW-1:0] la, input vec_t ld);
        vec_t res;
        instr_valid   = iv;
        instr_op      = op_t'($urandom_range(0, 7));
        instr_dst     = dst;
        instr_src     = src;
        instr_swizzle = 8'($urandom_range(0, 255));
        instr_wmask   = 4'($urandom_range(0, 15));
        ld_valid      = lv;
        ld_addr       = la;
        ld_data       = ld;
        #1;
        check("instr_ready", instr_ready, !lv);
        @(posedge clk);
        if (exp_q.size() > 0) begin
            exp_rv    = 1'b1;
            exp_rdst  = exp_q.pop_front();
            exp_flags = nzp_q.pop_front();
        end else begin
            exp_rv = 1'b0;
        end
        // Instructions take effect in order; a load at the retire edge lands after the retire.
        if (lv) begin
            m_regs[la] = ld;
        end else if (iv) begin
            exp_dest = m_regs[dst];
            exp_arg  = m_regs[src];
            exp_op   = instr_op;
            exp_swz  = instr_swizzle;
            exp_wm   = instr_wmask;
            res      = exp_dest ^ exp_arg;
            m_regs[dst] = res;
            exp_q.push_back(dst);
            nzp_q.push_back((res == '0) ? 3'b100 : 3'b001);
        end
        #1;
        check("busy", busy, exp_q.size() != 0);
        check("retire_valid", retire_valid, exp_rv);
        check("retire_dst", retire_dst, exp_rdst);
        check("flags_nzp", flags_nzp, exp_flags);
        check("alu_dest", alu_dest, exp_dest);
        check("alu_arg", alu_arg, exp_arg);
        check("alu_op", alu_op, exp_op);
        check("alu_swizzle", alu_swizzle, exp_swz);
        check("alu_write_mask", alu_write_mask, exp_wm);
    endtask

    task automatic issue(input logic [RAW-1:0] dst, input logic [RAW-1:0] src);
        step(1'b1, dst, src, 1'b0, '0, '0);
    endtask

    task automatic load(input logic [RAW-1:0] a, input vec_t d);
        step(1'b0, '0, '0, 1'b1, a, d);
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_retire_valid", retire_valid, 1'b0);
        check("rst_flags", flags_nzp, 3'b000);
        check("rst_alu_dest", alu_dest, '0);
        check("rst_alu_arg", alu_arg, '0);
        instr_valid = 1'b0;
        ld_valid    = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t rand_vec();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        vec_t ld_val;
        rst_n         = 1'b0;
        instr_valid   = 1'b0;
        instr_op      = '0;
        instr_dst     = '0;
        instr_src     = '0;
        instr_swizzle = '0;
        instr_wmask   = '0;
        ld_valid      = 1'b0;
        ld_addr       = '0;
        ld_data       = '0;
        model_reset();
        #12;
        apply_reset();

        // Reset mid-stream with S1 holding an instruction.
        load(3'd5, rand_vec());
        issue(3'd5, 3'd4);
        #2;
        apply_reset();
        issue(3'd0, 3'd0);
        idle();
        check("reset_r0_retire_dst", retire_dst, 3'd0);
        check("reset_r0_flags", flags_nzp, 3'b100);

        // Load then op.
        load(3'd1, 128'h0F);
        load(3'd2, 128'hF0);
        issue(3'd1, 3'd2);
        idle();
        check("ldop_retire_dst", retire_dst, 3'd1);
        check("ldop_flags", flags_nzp, 3'b001);
        issue(3'd1, 3'd0);
        check("ldop_r1", alu_dest, 128'hFF);
        idle();

        // Back-to-back dependent pair.
        load(3'd1, 128'd5);
        load(3'd2, 128'd3);
        issue(3'd1, 3'd2);
        issue(3'd2, 3'd1);
        check("b2b_fwd_arg", alu_arg, 128'd6);
        check("b2b_first_pulse", retire_valid, 1'b1);
        idle();
        check("b2b_second_pulse", retire_valid, 1'b1);
        issue(3'd1, 3'd0);
        check("b2b_r1", alu_dest, 128'd6);
        issue(3'd2, 3'd0);
        check("b2b_r2", alu_dest, 128'd5);
        idle();

        // Self-zero.
        load(3'd3, 128'hDEAD);
        issue(3'd3, 3'd3);
        idle();
        check("selfzero_flags", flags_nzp, 3'b100);
        issue(3'd3, 3'd0);
        check("selfzero_r3", alu_dest, 128'd0);
        idle();

        // Load priority: held instruction, then load colliding with a retire.
        step(1'b1, 3'd4, 3'd4, 1'b1, 3'd6, rand_vec());
        check("ldprio_not_busy", busy, 1'b0);
        issue(3'd4, 3'd4);
        issue(3'd1, 3'd2);
        ld_val = rand_vec();
        load(3'd1, ld_val);
        issue(3'd1, 3'd0);
        check("ldprio_r1_is_load", alu_dest, ld_val);

        // Idle hold after a retirement.
        issue(3'd2, 3'd6);
        idle();
        for (int i = 0; i < 3; i++) idle();
        check("idle_not_busy", busy, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            step($urandom_range(0, 3) != 0,
                 RAW'($urandom_range(0, NREGS - 1)), RAW'($urandom_range(0, NREGS - 1)),
                 $urandom_range(0, 5) == 0,
                 RAW'($urandom_range(0, NREGS - 1)), rand_vec());
            if (n == 150) begin
                #2;
                apply_reset();
            end
        end
        idle();
        idle();

        // ---------------- final report ----------------
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/vec_issue_unit.md
# vec_issue_unit

Operand-issue and writeback sequencer on the driving side of the shader core's 4-lane vector ALU. Accepts one vector instruction per cycle over a valid/ready handshake, fetches dest/arg operands from an internal 128-bit vector register file with one-stage forwarding, and presents them to the ALU from a registered issue stage. It retires the ALU's `dest_out` and `nzp_out` into the register file and the condition-flag register. A host load port preloads registers.

## Interface
- `NREGS`, 8: number of 128-bit vector registers.
- `RAW`, `$clog2(NREGS)`: register address width.

- `clk`  in  1  core clock
- `rst_n`  in  1  asynchronous, active-low reset
- `instr_valid`  in  1  instruction offered
- `instr_ready`  out  1  instruction accepted when high with `instr_valid`
- `instr_op`  in  3  ALU op, passed through
- `instr_dst`  in  RAW  destination register, also the ALU `dest` operand
- `instr_src`  in  RAW  source register, which becomes the ALU `arg`
- `instr_swizzle`  in  8  2-bit source-lane select per lane, passed through
- `instr_wmask`  in  4  per-lane write enable, passed through
- `ld_valid`  in  1  host register load
- `ld_addr`  in  RAW / `ld_data` in 128  load target and data
- `alu_dest`, `alu_arg`  out  128  registered operands to the ALU
- `alu_op`  out  3 / `alu_swizzle` out 8 / `alu_write_mask` out 4  registered controls
- `alu_dest_out`  in  128  ALU result
- `alu_nzp`  in  3  ALU OR-reduced condition flags
- `retire_valid`  out  1  one-cycle pulse per retired instruction
- `retire_dst`  out  RAW  register written by that retirement
- `flags_nzp`  out  3  last retired nzp
- `busy`  out  1  issue stage holds an instruction

## Operation
- Two stages:
  - **ACCEPT**: register-file read plus forward, then latch into the issue stage (S1).
  - **S1**: drives the ALU combinationally from its registers. The result is written back at the next edge.
- `instr_ready = !ld_valid`. Load has priority over issue. No other backpressure.
- Forwarding at accept:
  - If S1 is valid and `s1_dst == instr_src`, `arg` takes `alu_dest_out` instead of `regs[instr_src]`.
  - If S1 is valid and `s1_dst == instr_dst`, `dest` takes `alu_dest_out` in the same way.
  - Both forwards may apply at once.
- Retire at each edge where S1 is valid:
  - `regs[s1_dst] <= alu_dest_out` (full 128 bits; the ALU already applies the write mask).
  - `flags_nzp <= alu_nzp`.
  - `retire_valid` and `retire_dst` are registered and reflect that edge.
- S1 valid next cycle = accept this cycle. S1 is cleared when nothing is accepted, so `alu_*` holds its last values while `busy` = 0.
- Load writes `regs[ld_addr] <= ld_data`. If the same edge retires to the same address, the load wins.
- The register file and S1 are never read by the load path. Latched S1 operands are unaffected by a later load.

## Timing
- Reset (async assert, sync release): all registers 0, `flags_nzp` = 0, S1 invalid, `retire_valid` = 0, all `alu_*` = 0, `busy` = 0. `instr_ready` follows `ld_valid` combinationally.
- Latency: accept at edge N; ALU sees operands in cycle N..N+1; register write, `flags_nzp`, and `retire_valid` at edge N+1.
- Throughput is one instruction per cycle. Back-to-back dependent instructions need no stall because of forwarding.
- Reset mid-operation drops S1 with no retirement.

## Structure
- Shared package `shader_pkg`: `vec_t` (`logic [127:0]`), `op_t` (3-bit), and `nzp_t` (3-bit) typedefs, plus the `NREGS` default.
- One sub-module: `vec_regfile`. It has two async read ports, one retire write port, and one load write port with load priority.
- Forward muxes and S1 registers live in `vec_issue_unit`.
- The bench binds a behavioural ALU model: `dest_out = dest ^ arg`, `nzp = {dest_out == 0, 1'b0, dest_out != 0}`.

## Test plan
- **Reset**:
  - Stimulus: assert `rst_n` = 0 mid-stream with S1 valid.
  - Response: `busy` = 0, `retire_valid` = 0, `flags_nzp` = 0.
  - After release, a read via an instruction (r0 ^ r0) retires 0.
- **Load then op**:
  - Stimulus: load r1 = `0x…0F`, r2 = `0x…F0`, then issue dst=r1, src=r2.
  - Response: at edge N+1 r1 = `0x…FF`, `retire_dst` = 1, `flags_nzp` = 3'b001.
- **Back-to-back forward**:
  - Stimulus: r1 = 5, r2 = 3; issue r1 ^= r2, then immediately r2 ^= r1.
  - Response: second instruction sees `arg` = 6. Result: r1 = 6, r2 = 5, two consecutive `retire_valid` pulses.
- **Self-zero**:
  - Stimulus: issue dst=r3, src=r3 with r3 = `0xDEAD`.
  - Response: r3 = 0, `flags_nzp` = 3'b100.
- **Load priority**:
  - Stimulus: `ld_valid` high while `instr_valid` high.
  - Response: `instr_ready` = 0 and the instruction is held. A load to r1 on the same edge as a retire to r1 leaves r1 = `ld_data`.
- **Idle hold**:
  - Stimulus: no valid input for 3 cycles after a retirement.
  - Response: `busy` = 0, no `retire_valid` pulses, `flags_nzp` unchanged.
